// File: rtl/user_clock_pkg.sv
// Shared definitions for the user-clock reset sequencer.
//   seq_state_e : sequencer FSM state, 2-bit, encodings visible on STATE.
//   LockLossW   : width of the saturating lock-loss counter.
//   RetryW      : width of the saturating MMCM retry counter.
//   clog2/max3  : elaboration-time helpers for sizing the shared cycle counter.
package user_clock_pkg;

  typedef enum logic [1:0] {
    StResetMmcm = 2'd0,
    StWaitLock  = 2'd1,
    StStabilize = 2'd2,
    StRun       = 2'd3
  } seq_state_e;

  localparam int unsigned LockLossW = 8;
  localparam int unsigned RetryW    = 4;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    while ((64'd1 << result) < 64'(value)) begin
      result++;
    end
    return result;
  endfunction

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/user_clock_sync_bit.sv
// Multi-flop single-bit synchronizer with asynchronous active-high clear to 0.
//   clk_i : destination clock
//   clr_i : asynchronous clear, active high
//   d_i   : asynchronous input bit
//   q_o   : d_i delayed through SYNC_STAGES flops
module user_clock_sync_bit #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic clr_i,
  input  logic d_i,
  output logic q_o
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk_i or posedge clr_i) begin
    if (clr_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/user_clock_reset_sequencer.sv
// Sequences the user-clock MMCM: pulses MMCM_RST, waits for lock (retrying on timeout),
// requires a stable lock window, then releases the active-low user reset.
//   CLK             : free-running reference clock (also the MMCM input clock)
//   RST             : asynchronous active-high reset
//   LOCKED          : raw MMCM lock, asynchronous to CLK
//   MMCM_RST        : active-high MMCM reset
//   RST_N_OUT       : active-low user reset, released only in RUN
//   STATE           : current FSM state (seq_state_e encoding)
//   LOCK_LOSS_COUNT : saturating count of lock losses seen in RUN
//   RETRY_COUNT     : saturating count of lock timeouts
module user_clock_reset_sequencer
  import user_clock_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned STABLE_CYCLES   = 256,
  parameter int unsigned LOCK_TIMEOUT    = 65536,
  parameter int unsigned MMCM_RST_CYCLES = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 LOCKED,
  output logic                 MMCM_RST,
  output logic                 RST_N_OUT,
  output logic [1:0]           STATE,
  output logic [LockLossW-1:0] LOCK_LOSS_COUNT,
  output logic [RetryW-1:0]    RETRY_COUNT
);

  localparam int unsigned CNT_W = clog2(max3(STABLE_CYCLES, LOCK_TIMEOUT, MMCM_RST_CYCLES));

  localparam logic [CNT_W-1:0] MmcmRstLast = CNT_W'(MMCM_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] StableLast  = CNT_W'(STABLE_CYCLES - 1);

  seq_state_e           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [LockLossW-1:0] loss_q, loss_d;
  logic [RetryW-1:0]    retry_q, retry_d;
  logic                 mmcm_rst_q, mmcm_rst_d;
  logic                 rst_n_q, rst_n_d;
  logic                 locked_s;

  user_clock_sync_bit #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_lock_sync (
    .clk_i(CLK),
    .clr_i(RST),
    .d_i  (LOCKED),
    .q_o  (locked_s)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    loss_d  = loss_q;
    retry_d = retry_q;
    case (state_q)
      StResetMmcm: begin
        if (cnt_q == MmcmRstLast) begin
          state_d = StWaitLock;
          cnt_d   = '0;
        end
      end
      StWaitLock: begin
        // Lock takes priority over a timeout landing on the same cycle.
        if (locked_s) begin
          state_d = StStabilize;
          cnt_d   = '0;
        end else if (cnt_q == TimeoutLast) begin
          state_d = StResetMmcm;
          cnt_d   = '0;
          if (retry_q != '1) retry_d = retry_q + RetryW'(1);
        end
      end
      StStabilize: begin
        if (!locked_s) begin
          state_d = StWaitLock;
          cnt_d   = '0;
        end else if (cnt_q == StableLast) begin
          state_d = StRun;
          cnt_d   = '0;
        end
      end
      StRun: begin
        cnt_d = '0;
        // No MMCM reset on loss: the MMCM relocks itself, the timeout path covers failure.
        if (!locked_s) begin
          state_d = StWaitLock;
          if (loss_q != '1) loss_d = loss_q + LockLossW'(1);
        end
      end
      default: begin
        state_d = StResetMmcm;
        cnt_d   = '0;
      end
    endcase
    // Outputs follow the next state so they change on the same edge as the transition.
    mmcm_rst_d = (state_d == StResetMmcm);
    rst_n_d    = (state_d == StRun);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= StResetMmcm;
      cnt_q      <= '0;
      loss_q     <= '0;
      retry_q    <= '0;
      mmcm_rst_q <= 1'b1;
      rst_n_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      loss_q     <= loss_d;
      retry_q    <= retry_d;
      mmcm_rst_q <= mmcm_rst_d;
      rst_n_q    <= rst_n_d;
    end
  end

  assign MMCM_RST        = mmcm_rst_q;
  assign RST_N_OUT       = rst_n_q;
  assign STATE           = state_q;
  assign LOCK_LOSS_COUNT = loss_q;
  assign RETRY_COUNT     = retry_q;

endmodule

// File: tb/tb_user_clock_reset_sequencer.sv
// Bench for user_clock_reset_sequencer: directed plan steps plus randomized LOCKED
// patterns, every cycle compared against a phase/elapsed-time reference model.
module tb_user_clock_reset_sequencer;

  localparam int SyncStages    = 2;
  localparam int StableCycles  = 16;
  localparam int LockTimeout   = 64;
  localparam int MmcmRstCycles = 4;

  localparam int PhReset = 0;
  localparam int PhWait  = 1;
  localparam int PhStab  = 2;
  localparam int PhRun   = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       locked = 1'b0;
  logic       mmcm_rst;
  logic       rst_n_out;
  logic [1:0] state;
  logic [7:0] loss_cnt;
  logic [3:0] retry_cnt;
  logic [15:0] dut_vec;

  int total = 0;
  int bad   = 0;

  // Reference model: lock delay line, phase, cycles elapsed in phase, event tallies.
  bit m_dly [SyncStages];
  int m_phase;
  int m_n;
  int m_loss;
  int m_retry;

  always #5 clk = ~clk;

  user_clock_reset_sequencer #(
    .SYNC_STAGES    (SyncStages),
    .STABLE_CYCLES  (StableCycles),
    .LOCK_TIMEOUT   (LockTimeout),
    .MMCM_RST_CYCLES(MmcmRstCycles)
  ) dut (
    .CLK            (clk),
    .RST            (rst),
    .LOCKED         (locked),
    .MMCM_RST       (mmcm_rst),
    .RST_N_OUT      (rst_n_out),
    .STATE          (state),
    .LOCK_LOSS_COUNT(loss_cnt),
    .RETRY_COUNT    (retry_cnt)
  );

  assign dut_vec = {mmcm_rst, rst_n_out, state, loss_cnt, retry_cnt};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < SyncStages; i++) m_dly[i] = 1'b0;
    m_phase = PhReset;
    m_n     = 0;
    m_loss  = 0;
    m_retry = 0;
  endtask

  task automatic enter(input int ph);
    m_phase = ph;
    m_n     = 0;
  endtask

  task automatic model_step(input bit lk);
    bit ls;
    ls = m_dly[SyncStages-1];
    for (int i = SyncStages - 1; i > 0; i--) m_dly[i] = m_dly[i-1];
    m_dly[0] = lk;
    case (m_phase)
      PhReset: if (m_n == MmcmRstCycles - 1) enter(PhWait); else m_n++;
      PhWait: begin
        if (ls) enter(PhStab);
        else if (m_n == LockTimeout - 1) begin
          enter(PhReset);
          if (m_retry < 15) m_retry++;
        end else m_n++;
      end
      PhStab: begin
        if (!ls) enter(PhWait);
        else if (m_n == StableCycles - 1) enter(PhRun);
        else m_n++;
      end
      default: begin
        if (!ls) begin
          enter(PhWait);
          if (m_loss < 255) m_loss++;
        end
      end
    endcase
  endtask

  function automatic logic [15:0] model_vec();
    return {m_phase == PhReset, m_phase == PhRun, 2'(m_phase), 8'(m_loss), 4'(m_retry)};
  endfunction

  // One clock edge: advance the model with the LOCKED value the DUT samples, then compare.
  task automatic tick();
    bit lk;
    lk = locked;
    @(posedge clk);
    if (rst) model_reset();
    else model_step(lk);
    #1;
    chk("cycle", 32'(dut_vec), 32'(model_vec()));
  endtask

  initial begin
    model_reset();
    rst    = 1'b1;
    locked = 1'b0;
    repeat (3) tick();
    chk("reset_vec", 32'(dut_vec), 32'h8000);

    // Power-up: MMCM_RST high for exactly 4 edges after release.
    rst = 1'b0;
    for (int e = 1; e <= 4; e++) begin
      tick();
      if (e == 3) chk("pwr_mmcm_e3", 32'(mmcm_rst), 32'd1);
    end
    chk("pwr_mmcm_e4", 32'(mmcm_rst), 32'd0);
    chk("pwr_state", 32'(state), 32'd1);
    chk("pwr_rstn", 32'(rst_n_out), 32'd0);

    // Clean lock: release lands exactly on edge 19.
    locked = 1'b1;
    for (int e = 1; e <= 19; e++) begin
      tick();
      if (e == 18) chk("lock_rstn_e18", 32'(rst_n_out), 32'd0);
    end
    chk("lock_rstn_e19", 32'(rst_n_out), 32'd1);
    chk("lock_state", 32'(state), 32'd3);
    chk("lock_counts", 32'({loss_cnt, retry_cnt}), 32'd0);

    // Async reset mid-RUN, off-edge.
    #3 rst = 1'b1;
    #1;
    model_reset();
    chk("arst_run", 32'(dut_vec), 32'h8000);
    locked = 1'b0;
    tick();
    rst = 1'b0;
    repeat (4) tick();

    // Unstable lock: one-cycle drop during STABILIZE must be honoured.
    locked = 1'b1;
    repeat (10) tick();
    locked = 1'b0;
    tick();
    locked = 1'b1;
    for (int e = 1; e <= 19; e++) begin
      tick();
      if (e == 2) chk("glitch_state_wait", 32'(state), 32'd1);
      if (e == 3) chk("glitch_state_stab", 32'(state), 32'd2);
      if (e == 18) chk("glitch_rstn_e18", 32'(rst_n_out), 32'd0);
    end
    chk("glitch_rstn_e19", 32'(rst_n_out), 32'd1);
    chk("glitch_loss", 32'(loss_cnt), 32'd0);

    // Lock loss in RUN: user reset reasserts on the third edge.
    locked = 1'b0;
    for (int e = 1; e <= 3; e++) begin
      tick();
      if (e == 2) chk("loss_rstn_e2", 32'(rst_n_out), 32'd1);
    end
    chk("loss_rstn_e3", 32'(rst_n_out), 32'd0);
    chk("loss_cnt_1", 32'(loss_cnt), 32'd1);
    for (int k = 0; k < 299; k++) begin
      locked = 1'b1;
      repeat (19 + int'($urandom_range(0, 5))) tick();
      locked = 1'b0;
      repeat (3) tick();
    end
    chk("loss_cnt_sat", 32'(loss_cnt), 32'd255);

    // Timeout: 64 WAIT_LOCK cycles then a 4-cycle MMCM reset, retries saturate at 15.
    for (int e = 1; e <= 64; e++) begin
      tick();
      if (e == 63) chk("to_mmcm_e63", 32'(mmcm_rst), 32'd0);
    end
    chk("to_mmcm_e64", 32'(mmcm_rst), 32'd1);
    chk("to_retry_1", 32'(retry_cnt), 32'd1);
    chk("to_state_reset", 32'(state), 32'd0);
    for (int e = 1; e <= 4; e++) begin
      tick();
      if (e == 3) chk("to_mmcm_hold", 32'(mmcm_rst), 32'd1);
    end
    chk("to_mmcm_drop", 32'(mmcm_rst), 32'd0);
    chk("to_state_wait", 32'(state), 32'd1);
    repeat (19 * (LockTimeout + MmcmRstCycles)) tick();
    chk("to_retry_sat", 32'(retry_cnt), 32'd15);
    chk("to_loss_kept", 32'(loss_cnt), 32'd255);

    // Async reset mid-STABILIZE clears saturated counters too.
    locked = 1'b1;
    repeat (8) tick();
    chk("stab_state", 32'(state), 32'd2);
    #3 rst = 1'b1;
    #1;
    model_reset();
    chk("arst_stab", 32'(dut_vec), 32'h8000);
    locked = 1'b0;
    tick();
    rst = 1'b0;

    // Randomized LOCKED hold patterns against the model.
    for (int i = 0; i < 60; i++) begin
      locked = 1'($urandom_range(0, 1));
      repeat (int'($urandom_range(1, 40))) tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
